// File: rtl/alu_block.sv
// 8-bit ALU slice: four general registers, a 4-bit flags register and a
// combinational ALU, all sharing one tri-state main bus.
module alu_block (
  input  logic       clk,
  input  logic       rst,
  input  logic       iclk,
  inout  wire  [7:0] main_bus,
  input  logic [3:0] outctl,
  input  logic [3:0] loadctl,
  input  logic [1:0] arg_l,
  input  logic [2:0] arg_r,
  input  logic       alt,
  input  logic       calcfn,
  input  logic       cin
);

  localparam int unsigned DW   = 8;
  localparam int unsigned FW   = 4;
  localparam int unsigned NREG = 4;

  localparam logic [3:0] SEL_FLAGS = 4'd4;
  localparam logic [3:0] SEL_RES   = 4'd5;

  logic [DW-1:0] regs [NREG];
  logic [FW-1:0] fout;

  logic [DW-1:0] l_op;
  logic [DW-1:0] r_op;
  logic [DW-1:0] r_eff;
  logic [DW:0]   sum;
  logic [DW-1:0] res;
  logic          co;
  logic          ovf;
  logic [FW-1:0] flags_new;

  logic          bus_en;
  logic [DW-1:0] bus_val;

  // The sequencer's inverted clock is not needed in this slice.
  logic unused_iclk;
  assign unused_iclk = iclk;

  // Operand selection
  always_comb begin
    l_op = regs[arg_l];
  end

  always_comb begin
    r_op = '0;
    case (arg_r)
      3'd0, 3'd1, 3'd2, 3'd3: r_op = regs[arg_r[1:0]];
      3'd4:                   r_op = 8'h01;
      3'd5:                   r_op = 8'hFF;
      default:                r_op = '0;
    endcase
  end

  // ALU: overflow is judged against the effective (possibly inverted) right operand
  always_comb begin
    res   = '0;
    co    = 1'b0;
    ovf   = 1'b0;
    r_eff = alt ? ~r_op : r_op;
    sum   = {1'b0, l_op} + {1'b0, r_eff} + (DW+1)'(cin);
    if (!calcfn) begin
      res = sum[DW-1:0];
      co  = sum[DW];
      ovf = (l_op[DW-1] == r_eff[DW-1]) && (res[DW-1] != l_op[DW-1]);
    end else begin
      case ({alt, cin})
        2'b00:   res = l_op & r_op;
        2'b01:   res = l_op | r_op;
        2'b10:   res = l_op ^ r_op;
        default: begin
          res = l_op >> 1;
          co  = l_op[0];
        end
      endcase
    end
  end

  always_comb begin
    flags_new = {res[DW-1], (res == '0), co, ovf};
  end

  // Bus driver select
  always_comb begin
    bus_en  = 1'b1;
    bus_val = '0;
    case (outctl)
      4'd0, 4'd1, 4'd2, 4'd3: bus_val = regs[outctl[1:0]];
      SEL_FLAGS:              bus_val = {{(DW-FW){1'b0}}, fout};
      SEL_RES:                bus_val = res;
      default:                bus_en  = 1'b0;
    endcase
  end

  assign main_bus = bus_en ? bus_val : {DW{1'bz}};

  // Register file and flags; an explicit flags load beats the ALU flag update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
      fout <= '0;
    end else begin
      if (loadctl < 4'(NREG)) begin
        regs[loadctl[1:0]] <= main_bus;
      end
      if (loadctl == SEL_FLAGS) begin
        fout <= main_bus[FW-1:0];
      end else if (outctl == SEL_RES) begin
        fout <= flags_new;
      end
    end
  end

endmodule

// File: tb/tb_alu_block.sv
// Bench for alu_block: directed vector table, hand sequences, and random
// operations checked against an integer-arithmetic reference model.
module tb_alu_block;

  logic       clk = 1'b0;
  logic       rst;
  logic       iclk;
  wire  [7:0] main_bus;
  logic [3:0] outctl;
  logic [3:0] loadctl;
  logic [1:0] arg_l;
  logic [2:0] arg_r;
  logic       alt;
  logic       calcfn;
  logic       cin;

  logic       ext_en;
  logic [7:0] ext_val;

  int errors = 0;
  int checks = 0;

  int m_reg [4];
  int m_f;

  assign main_bus = ext_en ? ext_val : 8'bz;
  assign iclk = ~clk;

  always #5 clk = ~clk;

  alu_block dut (
    .clk(clk), .rst(rst), .iclk(iclk), .main_bus(main_bus),
    .outctl(outctl), .loadctl(loadctl), .arg_l(arg_l), .arg_r(arg_r),
    .alt(alt), .calcfn(calcfn), .cin(cin)
  );

  typedef struct {
    bit       cf;
    bit       al;
    bit       ci;
    bit [7:0] a;
    bit [7:0] b;
    bit [7:0] exp_res;
    bit [3:0] exp_f;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] src, output logic [7:0] v);
    outctl = src;
    #1;
    v = main_bus;
  endtask

  function automatic int operand_r(input int sel);
    case (sel)
      0, 1, 2, 3: return m_reg[sel];
      4:          return 1;
      5:          return 255;
      default:    return 0;
    endcase
  endfunction

  // Reference ALU from plain integer arithmetic
  function automatic void model_alu(input int l, input int r, input bit cf, input bit al,
                                    input bit ci, output int res, output int fl);
    int re, s, ls, rs, ss, c, v;
    c = 0;
    v = 0;
    if (!cf) begin
      re  = al ? 255 - r : r;
      s   = l + re + ci;
      res = s % 256;
      c   = s / 256;
      ls  = (l > 127) ? l - 256 : l;
      rs  = (re > 127) ? re - 256 : re;
      ss  = ls + rs + ci;
      v   = (ss > 127 || ss < -128) ? 1 : 0;
    end else if (!al && !ci) res = l & r;
    else if (!al && ci)      res = l | r;
    else if (al && !ci)      res = l ^ r;
    else begin
      res = l / 2;
      c   = l % 2;
    end
    fl = ((res > 127) ? 8 : 0) + ((res == 0) ? 4 : 0) + c * 2 + v;
  endfunction

  // External write of a register (0..3) or flags (4)
  task automatic wr(input int idx, input logic [7:0] v);
    outctl  = 4'd15;
    loadctl = 4'(idx);
    ext_val = v;
    ext_en  = 1'b1;
    step();
    ext_en  = 1'b0;
    loadctl = 4'd15;
    if (idx < 4) m_reg[idx] = int'(v);
    else if (idx == 4) m_f = int'(v[3:0]);
  endtask

  // ALU operation driven onto the bus, result loaded into dst
  task automatic exec(input bit cf, input bit al, input bit ci, input int l, input int r,
                      input int dst);
    int res, fl;
    logic [7:0] b;
    model_alu(m_reg[l], operand_r(r), cf, al, ci, res, fl);
    ext_en  = 1'b0;
    calcfn  = cf;
    alt     = al;
    cin     = ci;
    arg_l   = 2'(l);
    arg_r   = 3'(r);
    loadctl = 4'(dst);
    rd(4'd5, b);
    chk("bus_res", int'(b), res);
    step();
    if (dst < 4) begin
      m_reg[dst] = res;
      m_f = fl;
    end else if (dst == 4) begin
      m_f = res % 16;
    end else begin
      m_f = fl;
    end
    loadctl = 4'd15;
    outctl  = 4'd15;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      rd(4'(i), b);
      chk({tag, "_reg"}, int'(b), m_reg[i]);
    end
    rd(4'd4, b);
    chk({tag, "_fout"}, int'(b), m_f);
    outctl = 4'd15;
  endtask

  initial begin
    vec_t vecs [11];
    logic [7:0] b;

    rst = 1'b1; ext_en = 1'b0; ext_val = '0; outctl = 4'd15; loadctl = 4'd15;
    arg_l = '0; arg_r = '0; alt = 1'b0; calcfn = 1'b0; cin = 1'b0;

    vecs[0]  = '{0, 1, 1, 8'h05, 8'h07, 8'hFE, 4'b1000};
    vecs[1]  = '{0, 0, 0, 8'h7F, 8'h01, 8'h80, 4'b1001};
    vecs[2]  = '{1, 0, 0, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[3]  = '{1, 0, 1, 8'hF0, 8'h3C, 8'hFC, 4'b1000};
    vecs[4]  = '{1, 1, 0, 8'hF0, 8'h3C, 8'hCC, 4'b1000};
    vecs[5]  = '{1, 1, 1, 8'h03, 8'h3C, 8'h01, 4'b0010};
    vecs[6]  = '{0, 0, 0, 8'hFF, 8'h01, 8'h00, 4'b0110};
    vecs[7]  = '{0, 0, 0, 8'h80, 8'h80, 8'h00, 4'b0111};
    vecs[8]  = '{0, 1, 1, 8'h80, 8'h01, 8'h7F, 4'b0011};
    vecs[9]  = '{0, 0, 1, 8'h0F, 8'h01, 8'h11, 4'b0000};
    vecs[10] = '{1, 1, 1, 8'h80, 8'h00, 8'h40, 4'b0000};

    // Reset state
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_f = 0;
    check_all("reset");

    // 24 + 18 into A
    wr(0, 8'd24);
    wr(1, 8'd18);
    exec(0, 0, 0, 0, 1, 0);
    rd(4'd0, b); chk("add_42", int'(b), 42);
    rd(4'd4, b); chk("add_42_f", int'(b), 0);

    // 42 + 214 wraps to zero with carry
    wr(1, 8'd214);
    exec(0, 0, 0, 0, 1, 0);
    rd(4'd0, b); chk("wrap_zero", int'(b), 0);
    rd(4'd4, b); chk("wrap_zero_f", int'(b), 8'h06);

    // Directed vector table, result into C
    foreach (vecs[i]) begin
      wr(0, vecs[i].a);
      wr(1, vecs[i].b);
      exec(vecs[i].cf, vecs[i].al, vecs[i].ci, 0, 1, 2);
      rd(4'd2, b); chk("vec_res", int'(b), int'(vecs[i].exp_res));
      rd(4'd4, b); chk("vec_f", int'(b), int'(vecs[i].exp_f));
    end

    // High-Z bus readable from outside; explicit flags load
    outctl = 4'd15; ext_val = 8'h5A; ext_en = 1'b1;
    #1;
    chk("hiz_ext", int'(main_bus), 8'h5A);
    ext_en = 1'b0;
    wr(4, 8'h0A);
    rd(4'd4, b); chk("flags_load", int'(b), 8'h0A);

    // Flags bus load wins over the ALU flag update in the same cycle
    wr(0, 8'h7F); wr(1, 8'h01);
    exec(0, 0, 0, 0, 1, 4);
    rd(4'd4, b); chk("flags_priority", int'(b), 0);

    // Random operations against the model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) wr($urandom_range(0, 3), 8'($urandom()));
      exec(1'($urandom()), 1'($urandom()), 1'($urandom()),
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
      check_all("rand");
    end

    // Reset mid-sequence overrides a pending load
    wr(2, 8'h33);
    rst = 1'b1; outctl = 4'd15; loadctl = 4'd0; ext_val = 8'hFF; ext_en = 1'b1;
    step();
    rst = 1'b0; ext_en = 1'b0; loadctl = 4'd15;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_f = 0;
    check_all("mid_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
